logic_unit_pipe: RTL

- Parametrised, pipelined bitwise logic unit; successor to the fixed 8-bit AND slice.
- Applies a selectable bitwise op (AND/OR/XOR/NAND) to two WIDTH-bit operands.
- Result passes through a STAGES-deep register pipeline with valid/ready flow control.
- Sits between operand-select muxes and the writeback/flag logic of the ALU datapath.

---
 rtl/logic_unit_defs.sv | 20 ++
 rtl/logic_unit_stage.sv | 39 +++
 rtl/logic_unit_pipe.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/logic_unit_defs.sv
`default_nettype none
// ============================================================================
// Module : logic_unit_defs (package)
// Brief  : Op encodings and legal parameter ranges for the pipelined logic unit.
// Rev    : 1.0
// ============================================================================
package logic_unit_defs;

    localparam logic [1:0] OP_AND  = 2'd0;
    localparam logic [1:0] OP_OR   = 2'd1;
    localparam logic [1:0] OP_XOR  = 2'd2;
    localparam logic [1:0] OP_NAND = 2'd3;

    localparam int WIDTH_MIN  = 1;
    localparam int WIDTH_MAX  = 64;
    localparam int STAGES_MIN = 1;
    localparam int STAGES_MAX = 4;

endpackage
`default_nettype wire

// File: rtl/logic_unit_stage.sv
`default_nettype none
// ============================================================================
// Module : logic_unit_stage
// Brief  : One valid+data pipeline register that loads when its advance is high.
// Rev    : 1.0
// ============================================================================
module logic_unit_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_adv,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // Data only loads with a valid beat so bubbles leave the register untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_adv) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/logic_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module : logic_unit_pipe
// Brief  : WIDTH-bit AND/OR/XOR/NAND unit behind a STAGES-deep valid/ready pipe.
//          Optional accumulator operand enabled by LOGIC_UNIT_ACC_EN.
// Rev    : 1.0
// ============================================================================
module logic_unit_pipe
    import logic_unit_defs::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic [1:0]       op,
`ifdef LOGIC_UNIT_ACC_EN
    input  logic             accMode,
    input  logic             accClr,
`endif
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             ones
);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX ||
        STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_params
        $error("logic_unit_pipe: WIDTH or STAGES out of range");
    end

    logic [WIDTH-1:0] w_opb;
    logic [WIDTH-1:0] w_func;
    wire  [WIDTH-1:0] w_and;
    wire  [WIDTH-1:0] w_or;
    wire  [WIDTH-1:0] w_xor;
    wire  [WIDTH-1:0] w_nand;

`ifdef LOGIC_UNIT_ACC_EN
    logic [WIDTH-1:0] r_acc;

    // A clear coinciding with an accumulating beat feeds zero into that beat.
    assign w_opb = accMode ? (accClr ? '0 : r_acc) : inB;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= '0;
        end else if (inValid && inReady && accMode) begin
            r_acc <= w_func;
        end else if (accClr) begin
            r_acc <= '0;
        end
    end
`else
    assign w_opb = inB;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        and  u_and  (w_and[i],  inA[i], w_opb[i]);
        or   u_or   (w_or[i],   inA[i], w_opb[i]);
        xor  u_xor  (w_xor[i],  inA[i], w_opb[i]);
        nand u_nand (w_nand[i], inA[i], w_opb[i]);
    end

    always_comb begin
        case (op)
            OP_AND:  w_func = w_and;
            OP_OR:   w_func = w_or;
            OP_XOR:  w_func = w_xor;
            default: w_func = w_nand;
        endcase
    end

    logic [STAGES-1:0] w_valid;
    logic [STAGES-1:0] w_adv;
    logic [WIDTH-1:0]  w_data [STAGES];

    // adv[k] = !v[k] || adv[k+1] unrolled: a stage moves if outReady or any
    // stage at or after it is empty. Built from registered valids only.
    always_comb begin
        w_adv = '0;
        for (int k = 0; k < STAGES; k++) begin
            w_adv[k] = outReady;
            for (int j = k; j < STAGES; j++) begin
                if (!w_valid[j]) begin
                    w_adv[k] = 1'b1;
                end
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             w_in_valid;
        logic [WIDTH-1:0] w_in_data;

        if (k == 0) begin : g_src_input
            assign w_in_valid = inValid;
            assign w_in_data  = w_func;
        end else begin : g_src_prev
            assign w_in_valid = w_valid[k-1];
            assign w_in_data  = w_data[k-1];
        end

        logic_unit_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk     (clk),
            .rst     (reset),
            .i_adv   (w_adv[k]),
            .i_valid (w_in_valid),
            .i_data  (w_in_data),
            .o_valid (w_valid[k]),
            .o_data  (w_data[k])
        );
    end

    logic             w_last_in_valid;
    logic [WIDTH-1:0] w_last_in;

    if (STAGES == 1) begin : g_flag_src_input
        assign w_last_in_valid = inValid;
        assign w_last_in       = w_func;
    end else begin : g_flag_src_pipe
        assign w_last_in_valid = w_valid[STAGES-2];
        assign w_last_in       = w_data[STAGES-2];
    end

    logic r_zero;
    logic r_ones;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_zero <= 1'b0;
            r_ones <= 1'b0;
        end else if (w_adv[STAGES-1] && w_last_in_valid) begin
            r_zero <= ~|w_last_in;
            r_ones <= &w_last_in;
        end
    end

    assign inReady  = w_adv[0];
    assign outValid = w_valid[STAGES-1];
    assign out      = w_data[STAGES-1];
    assign zero     = r_zero;
    assign ones     = r_ones;

endmodule
`default_nettype wire
